// File: rtl/mps_pkg.sv
// Shared types and constants for the multi-project selector.
package mps_pkg;

  // Controller states; encoding is visible in STATUS[5:4].
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RESET = 2'd2
  } mps_state_e;

  // Word offsets inside the 16-byte register window (address bits [3:2]).
  localparam logic [1:0] OFF_SEL      = 2'd0;
  localparam logic [1:0] OFF_SETTINGS = 2'd1;
  localparam logic [1:0] OFF_RST_LEN  = 2'd2;
  localparam logic [1:0] OFF_STATUS   = 2'd3;

  // Cycles the pads stay floated before designs are forced into reset.
  localparam logic [7:0] DRAIN_LEN = 8'd2;

  // Upper bound on hosted designs; the select field is 4 bits wide.
  localparam int MAX_PROJ = 16;

  // A reset-hold length of zero would never expire cleanly, so it is stored as one.
  function automatic logic [7:0] clamp_rst_len(input logic [7:0] value);
    return (value == 8'd0) ? 8'd1 : value;
  endfunction

endpackage

// File: rtl/mps_wb_regs.sv
// Wishbone slave: address decode, single-cycle ack, register file and error flag.
module mps_wb_regs
  import mps_pkg::*;
#(
  parameter int          N_PROJ      = 4,
  parameter int          SET_W       = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          RST_LEN_DEF = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stb,
  input  logic             cyc,
  input  logic             we,
  input  logic [3:0]       sel,
  input  logic [31:0]      adr,
  input  logic [31:0]      dat_i,
  output logic             ack,
  output logic [31:0]      dat_o,
  input  logic [1:0]       state,
  input  logic [3:0]       cur_sel,
  output logic [3:0]       req_sel,
  output logic [SET_W-1:0] shadow,
  output logic [7:0]       rst_len,
  output logic             sel_go
);

  localparam logic [4:0] N_PROJ_W = 5'(N_PROJ);

  logic             hit_s;
  logic             access_s;
  logic             wr_s;
  logic             sel_valid_s;
  logic [1:0]       word_s;
  logic [31:0]      rdata_s;
  logic             unused_bits_s;

  logic             ack_r;
  logic [31:0]      dat_r;
  logic [3:0]       req_sel_r;
  logic [SET_W-1:0] shadow_r;
  logic [7:0]       rst_len_r;
  logic             err_r;
  logic             sel_go_r;

  // Decode the bus cycle; an access is refused in the ack cycle to force 2-cycle spacing.
  always_comb begin
    hit_s       = (adr[31:4] == BASE_ADDR[31:4]);
    access_s    = stb & cyc & hit_s & ~ack_r;
    wr_s        = access_s & we;
    word_s      = adr[3:2];
    sel_valid_s = ({1'b0, dat_i[3:0]} < N_PROJ_W);
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      OFF_SEL:      rdata_s = {28'd0, req_sel_r};
      OFF_SETTINGS: rdata_s = {{(32-SET_W){1'b0}}, shadow_r};
      OFF_RST_LEN:  rdata_s = {24'd0, rst_len_r};
      OFF_STATUS:   rdata_s = {23'd0, err_r, 2'd0, state, cur_sel};
      default:      rdata_s = 32'd0;
    endcase
  end

  // Register file, ack/read-data pipeline and select-request pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r     <= 1'b0;
      dat_r     <= 32'd0;
      req_sel_r <= 4'd0;
      shadow_r  <= {SET_W{1'b0}};
      rst_len_r <= 8'(RST_LEN_DEF);
      err_r     <= 1'b0;
      sel_go_r  <= 1'b0;
    end else begin
      ack_r    <= access_s;
      sel_go_r <= 1'b0;
      dat_r    <= (access_s && !we) ? rdata_s : 32'd0;
      if (wr_s) begin
        case (word_s)
          OFF_SEL: begin
            if (sel[0]) begin
              if (sel_valid_s) begin
                req_sel_r <= dat_i[3:0];
                sel_go_r  <= 1'b1;
              end else begin
                err_r <= 1'b1;
              end
            end
          end
          OFF_SETTINGS: begin
            if (sel[0]) shadow_r <= dat_i[SET_W-1:0];
          end
          OFF_RST_LEN: begin
            if (sel[0]) rst_len_r <= clamp_rst_len(dat_i[7:0]);
          end
          OFF_STATUS: begin
            if (sel[1] && dat_i[8]) err_r <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign unused_bits_s = ^{adr[1:0], dat_i[31:9], sel[3:2]};

  assign ack     = ack_r;
  assign dat_o   = dat_r;
  assign req_sel = req_sel_r;
  assign shadow  = shadow_r;
  assign rst_len = rst_len_r;
  assign sel_go  = sel_go_r;

endmodule

// File: rtl/multi_project_selector.sv
// Hosts N_PROJ user designs on one pad bank; switching drains the pads, holds
// every design in reset, latches settings and then releases the chosen design.
module multi_project_selector
  import mps_pkg::*;
#(
  parameter int          N_PROJ      = 4,
  parameter int          IO_W        = 33,
  parameter int          SET_W       = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          RST_LEN_DEF = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic                     pad_rst_n,
  output logic [N_PROJ-1:0]        proj_rst,
  output logic [SET_W-1:0]         proj_settings,
  input  logic [N_PROJ*IO_W-1:0]   proj_io_out,
  input  logic [N_PROJ*IO_W-1:0]   proj_io_oeb,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb
);

  localparam logic [N_PROJ-1:0] ALL_RST  = {N_PROJ{1'b1}};
  localparam logic [N_PROJ-1:0] ONE_HOT0 = {{(N_PROJ-1){1'b0}}, 1'b1};
  localparam logic [IO_W-1:0]   PAD_ZERO = {IO_W{1'b0}};
  localparam logic [IO_W-1:0]   PAD_FLT  = {IO_W{1'b1}};

  logic [3:0]       req_sel_s;
  logic [SET_W-1:0] shadow_s;
  logic [7:0]       rst_len_s;
  logic             sel_go_s;
  logic             pad_ok_s;

  logic [IO_W-1:0]  out_arr [MAX_PROJ];
  logic [IO_W-1:0]  oeb_arr [MAX_PROJ];

  logic [1:0]       pad_sync_r;
  mps_state_e       state_r;
  logic [7:0]       cnt_r;
  logic [3:0]       cur_sel_r;
  logic [SET_W-1:0] settings_r;
  logic [N_PROJ-1:0] proj_rst_r;
  logic [IO_W-1:0]  io_out_r;
  logic [IO_W-1:0]  io_oeb_r;

  mps_wb_regs #(
    .N_PROJ      (N_PROJ),
    .SET_W       (SET_W),
    .BASE_ADDR   (BASE_ADDR),
    .RST_LEN_DEF (RST_LEN_DEF)
  ) u_regs (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .stb     (wbs_stb_i),
    .cyc     (wbs_cyc_i),
    .we      (wbs_we_i),
    .sel     (wbs_sel_i),
    .adr     (wbs_adr_i),
    .dat_i   (wbs_dat_i),
    .ack     (wbs_ack_o),
    .dat_o   (wbs_dat_o),
    .state   (state_r),
    .cur_sel (cur_sel_r),
    .req_sel (req_sel_s),
    .shadow  (shadow_s),
    .rst_len (rst_len_s),
    .sel_go  (sel_go_s)
  );

  // Unpack the flattened design buses into a fixed 16-entry table indexed by a 4-bit select.
  for (genvar k = 0; k < MAX_PROJ; k++) begin : g_unpack
    if (k < N_PROJ) begin : g_used
      assign out_arr[k] = proj_io_out[k*IO_W +: IO_W];
      assign oeb_arr[k] = proj_io_oeb[k*IO_W +: IO_W];
    end else begin : g_unused
      assign out_arr[k] = PAD_ZERO;
      assign oeb_arr[k] = PAD_FLT;
    end
  end

  // Two-flop synchroniser for the external reset pin; idles high so it adds no hold after wb reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pad_sync_r <= 2'b11;
    end else begin
      pad_sync_r <= {pad_sync_r[0], pad_rst_n};
    end
  end

  assign pad_ok_s = pad_sync_r[1];

  // Switch controller: state, shared drain/reset counter and all registered pad/reset outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= ST_RESET;
      cnt_r      <= 8'd0;
      cur_sel_r  <= 4'd0;
      settings_r <= {SET_W{1'b0}};
      proj_rst_r <= ALL_RST;
      io_out_r   <= PAD_ZERO;
      io_oeb_r   <= PAD_FLT;
    end else if (!pad_ok_s) begin
      state_r    <= ST_RESET;
      cnt_r      <= 8'd0;
      proj_rst_r <= ALL_RST;
      io_out_r   <= PAD_ZERO;
      io_oeb_r   <= PAD_FLT;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (sel_go_s) begin
            state_r  <= ST_DRAIN;
            cnt_r    <= 8'd0;
            io_out_r <= PAD_ZERO;
            io_oeb_r <= PAD_FLT;
          end else begin
            proj_rst_r <= ~(ONE_HOT0 << cur_sel_r);
            io_out_r   <= out_arr[cur_sel_r];
            io_oeb_r   <= oeb_arr[cur_sel_r];
          end
        end
        ST_DRAIN: begin
          io_out_r <= PAD_ZERO;
          io_oeb_r <= PAD_FLT;
          if (cnt_r >= (DRAIN_LEN - 8'd1)) begin
            state_r    <= ST_RESET;
            cnt_r      <= 8'd0;
            proj_rst_r <= ALL_RST;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RESET: begin
          if (sel_go_s) begin
            cnt_r      <= 8'd0;
            proj_rst_r <= ALL_RST;
            io_out_r   <= PAD_ZERO;
            io_oeb_r   <= PAD_FLT;
          end else if (cnt_r >= (rst_len_s - 8'd1)) begin
            state_r    <= ST_RUN;
            cnt_r      <= 8'd0;
            cur_sel_r  <= req_sel_s;
            settings_r <= shadow_s;
            proj_rst_r <= ~(ONE_HOT0 << req_sel_s);
            io_out_r   <= out_arr[req_sel_s];
            io_oeb_r   <= oeb_arr[req_sel_s];
          end else begin
            cnt_r      <= cnt_r + 8'd1;
            proj_rst_r <= ALL_RST;
            io_out_r   <= PAD_ZERO;
            io_oeb_r   <= PAD_FLT;
          end
        end
        default: begin
          state_r    <= ST_RESET;
          cnt_r      <= 8'd0;
          proj_rst_r <= ALL_RST;
          io_out_r   <= PAD_ZERO;
          io_oeb_r   <= PAD_FLT;
        end
      endcase
    end
  end

  assign proj_rst      = proj_rst_r;
  assign proj_settings = settings_r;
  assign io_out        = io_out_r;
  assign io_oeb        = io_oeb_r;

endmodule

// File: tb/tb_multi_project_selector.sv
// Directed self-checking bench for multi_project_selector (N_PROJ=4, IO_W=33).
module tb_multi_project_selector;

  localparam logic [32:0] OUT0  = 33'h1_0102_0304;
  localparam logic [32:0] OUT1  = 33'h0_1111_2222;
  localparam logic [32:0] OUT2  = 33'h1_AAAA_5555;
  localparam logic [32:0] OUT3  = 33'h0_DEAD_BEEF;
  localparam logic [32:0] OEB0  = 33'h0_0000_0000;
  localparam logic [32:0] OEB1  = 33'h1_FFFF_0000;
  localparam logic [32:0] OEB2  = 33'h0_F0F0_F0F0;
  localparam logic [32:0] OEB3  = 33'h1_0000_FFFF;
  localparam logic [32:0] FLOAT = {33{1'b1}};
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic         clk;
  logic         wb_rst;
  logic         stb, cyc, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat_w;
  logic         ack;
  logic [31:0]  dat_r;
  logic         pad_rst_n;
  logic [3:0]   proj_rst;
  logic [1:0]   proj_settings;
  logic [131:0] proj_io_out;
  logic [131:0] proj_io_oeb;
  logic [32:0]  io_out;
  logic [32:0]  io_oeb;

  int n_checks = 0;
  int n_err    = 0;

  assign proj_io_out = {OUT3, OUT2, OUT1, OUT0};
  assign proj_io_oeb = {OEB3, OEB2, OEB1, OEB0};

  multi_project_selector dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat_w),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat_r),
    .pad_rst_n     (pad_rst_n),
    .proj_rst      (proj_rst),
    .proj_settings (proj_settings),
    .proj_io_out   (proj_io_out),
    .proj_io_oeb   (proj_io_oeb),
    .io_out        (io_out),
    .io_oeb        (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns two negedges later with the bus idle.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    check("wr_ack", 64'(ack), 64'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    check("wr_ack_drop", 64'(ack), 64'd0);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("rd_ack", 64'(ack), 64'd1);
    d = dat_r;
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    check("rd_ack_drop", 64'(ack), 64'd0);
    check("rd_dat_drop", 64'(dat_r), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          cnt;
    logic        found;

    wb_rst = 1'b1; pad_rst_n = 1'b1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat_w = 32'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    wb_rst = 1'b0;

    // Reset state
    check("rst_proj_rst", 64'(proj_rst), 64'hF);
    check("rst_io_oeb", 64'(io_oeb), 64'(FLOAT));
    check("rst_io_out", 64'(io_out), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(dat_r), 64'd0);
    check("rst_settings", 64'(proj_settings), 64'd0);

    // Default reset hold of 16 cycles, then design 0 runs
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("rst_hold", 64'(proj_rst), 64'hF);
    end
    @(negedge clk);
    check("run0_rst", 64'(proj_rst), 64'hE);
    check("run0_out", 64'(io_out), 64'(OUT0));
    check("run0_oeb", 64'(io_oeb), 64'(OEB0));

    // Register defaults
    wb_read(BASE + 32'hC, rd); check("status_dflt", 64'(rd), 64'h0);
    wb_read(BASE + 32'h8, rd); check("rstlen_dflt", 64'(rd), 64'h10);
    wb_read(BASE + 32'h0, rd); check("sel_dflt", 64'(rd), 64'h0);

    // SETTINGS only reaches the design at the next reset exit
    wb_write(BASE + 32'h4, 32'h0000_0002, 4'h1);
    check("settings_held", 64'(proj_settings), 64'h0);
    wb_read(BASE + 32'h4, rd); check("settings_rd", 64'(rd), 64'h2);

    // Switch to design 2 with a 3-cycle reset hold
    wb_write(BASE + 32'h8, 32'h0000_0003, 4'h1);
    wb_read(BASE + 32'h8, rd); check("rstlen_rd", 64'(rd), 64'h3);
    wb_write(BASE + 32'h0, 32'h0000_0002, 4'h1);
    check("drain_oeb", 64'(io_oeb), 64'(FLOAT));
    check("drain_out", 64'(io_out), 64'd0);
    check("drain_rst", 64'(proj_rst), 64'hE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sw_float_oeb", 64'(io_oeb), 64'(FLOAT));
      check("sw_float_out", 64'(io_out), 64'd0);
    end
    check("sw_reset_rst", 64'(proj_rst), 64'hF);
    @(negedge clk);
    check("run2_rst", 64'(proj_rst), 64'hB);
    check("run2_out", 64'(io_out), 64'(OUT2));
    check("run2_oeb", 64'(io_oeb), 64'(OEB2));
    check("run2_settings", 64'(proj_settings), 64'h2);
    wb_read(BASE + 32'hC, rd); check("status_run2", 64'(rd), 64'h2);

    // Out-of-range select sets err and does not switch
    wb_write(BASE + 32'h0, 32'h0000_0005, 4'h1);
    wb_read(BASE + 32'hC, rd); check("status_err", 64'(rd), 64'h102);
    check("bad_sel_rst", 64'(proj_rst), 64'hB);
    check("bad_sel_oeb", 64'(io_oeb), 64'(OEB2));
    wb_read(BASE + 32'h0, rd); check("sel_kept", 64'(rd), 64'h2);
    wb_write(BASE + 32'hC, 32'h0000_0100, 4'h2);
    wb_read(BASE + 32'hC, rd); check("err_clear", 64'(rd), 64'h2);

    // Byte lanes: SEL write without lane 0 is ignored
    wb_write(BASE + 32'h0, 32'h0000_0001, 4'hE);
    wb_read(BASE + 32'h0, rd); check("lane_sel", 64'(rd), 64'h2);
    check("lane_no_switch", 64'(proj_rst), 64'hB);

    // RST_LEN: zero stored as one, upper bits dropped
    wb_write(BASE + 32'h8, 32'h0000_0000, 4'h1);
    wb_read(BASE + 32'h8, rd); check("rstlen_zero", 64'(rd), 64'h1);
    wb_write(BASE + 32'h8, 32'hFFFF_FF04, 4'hF);
    wb_read(BASE + 32'h8, rd); check("rstlen_mask", 64'(rd), 64'h4);

    // Non-hit address: no ack, zero data
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("nohit_ack", 64'(ack), 64'd0);
    check("nohit_dat", 64'(dat_r), 64'd0);
    @(negedge clk);
    check("nohit_ack2", 64'(ack), 64'd0);
    stb = 1'b0; cyc = 1'b0;

    // Reselecting the active design still drains and resets (2 + 4 cycles)
    wb_write(BASE + 32'h0, 32'h0000_0002, 4'h1);
    check("resel_drain", 64'(io_oeb), 64'(FLOAT));
    repeat (5) @(negedge clk);
    check("resel_reset", 64'(proj_rst), 64'hF);
    @(negedge clk);
    check("resel_run", 64'(proj_rst), 64'hB);

    // External reset pin mid-RUN
    pad_rst_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (proj_rst == 4'hF && io_oeb == FLOAT) found = 1'b1;
    end
    check("pad_force", 64'(found), 64'd1);
    repeat (5) @(negedge clk);
    check("pad_hold", 64'(proj_rst), 64'hF);
    wb_read(BASE + 32'hC, rd); check("status_pad", 64'(rd), 64'h22);
    pad_rst_n = 1'b1;
    cnt = 0;
    while (proj_rst == 4'hF && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("pad_release_lat", 64'(cnt), 64'd6);
    check("pad_run_rst", 64'(proj_rst), 64'hB);
    check("pad_run_out", 64'(io_out), 64'(OUT2));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
